// File: rtl/sim_dwfifo_w2n.sv
// sim_dwfifo_w2n -- single-clock FIFO that stores double-width entries and
// delivers them as WIDTH-wide words, low half first. Each entry carries one
// (low only) or two (low then high) valid halves.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset (priority over flush_i)
//   flush_i   discard all contents this cycle; blocks writes and pops
//   wvalid_i  write request
//   wdata_i   entry data, [WIDTH-1:0] is the low half (delivered first)
//   wpair_i   1 = both halves valid, 0 = only the low half valid
//   wready_o  write accepted when wvalid_i && wready_o
//   rvalid_o  rdata_o holds a valid word
//   rdata_o   current narrow word
//   rready_i  consumer takes the word when rvalid_o && rready_i
//   count_o   number of occupied wide entries
module sim_dwfifo_w2n #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wvalid_i,
  input  logic [2*WIDTH-1:0]       wdata_i,
  input  logic                     wpair_i,
  output logic                     wready_o,
  output logic                     rvalid_o,
  output logic [WIDTH-1:0]         rdata_o,
  input  logic                     rready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] ram_mem  [DEPTH];
  logic               pair_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] cnt_reg,    cnt_next;
  logic          sel_reg,    sel_next;

  logic wr_en;
  logic pop;
  logic retire;

  // While rst is high the outputs already reflect the reset state, so a
  // consumer never sees stale contents during the reset cycle itself.
  assign wready_o = !flush_i && (rst || (cnt_reg != CW'(DEPTH)));
  assign rvalid_o = !rst && (cnt_reg != '0);
  assign count_o  = rst ? '0 : cnt_reg;
  assign rdata_o  = sel_reg ? ram_mem[rd_ptr_reg][2*WIDTH-1:WIDTH]
                            : ram_mem[rd_ptr_reg][WIDTH-1:0];

  assign wr_en  = wvalid_i && wready_o && !rst;
  // Pops during a flush are ignored; the flush clears everything anyway.
  assign pop    = rvalid_o && rready_i && !flush_i;
  // A pair entry stays after its low half is taken; only the last half
  // consumed retires the entry.
  assign retire = pop && (sel_reg || !pair_mem[rd_ptr_reg]);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    sel_next    = sel_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      cnt_next    = '0;
      sel_next    = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (retire) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
        sel_next    = 1'b0;
      end else if (pop) begin
        sel_next = 1'b1;
      end
      case ({wr_en, retire})
        2'b10:   cnt_next = cnt_reg + 1'b1;
        2'b01:   cnt_next = cnt_reg - 1'b1;
        default: cnt_next = cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      sel_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
    end
  end

  // Storage is not cleared by reset or flush; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram_mem[wr_ptr_reg]  <= wdata_i;
      pair_mem[wr_ptr_reg] <= wpair_i;
    end
  end

  cnt_bound_a: assert property (@(posedge clk) disable iff (rst)
    cnt_reg <= CW'(DEPTH));

endmodule
